// File: rtl/instruction_fetch.sv
// instruction_fetch: program-counter owner and IF/ID pipeline register.
// Drives the PC to instruction memory, samples the returned word in the same
// cycle and loads IF/ID, applying redirect > flush > hold > conflict > fetch.
// Optional feature macro: INSTRUCTION_FETCH_PERF_EN builds the fetch/bubble
// performance counters; without it both counter ports read 16'h0000.
module instruction_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned PC_STEP  = 4,
  parameter logic [15:0] NOP_WORD = 16'b0000100000000000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_pc,
  input  logic [15:0] imem_instr,
  input  logic        mem_conflict,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic [15:0] id_instr,
  output logic [15:0] id_pc,
  output logic [15:0] id_pc_next,
  output logic        id_valid,
  output logic [15:0] perf_fetched,
  output logic [15:0] perf_bubbles
);

  localparam int unsigned W = 16;
  localparam logic [W-1:0] STEP = W'(PC_STEP);

  typedef enum logic [2:0] {
    C_REDIRECT,
    C_FLUSH,
    C_HOLD,
    C_CONFLICT,
    C_FETCH
  } fetch_case_e;

  fetch_case_e  case_c;
  logic [W-1:0] pc_q, pc_d;
  logic [W-1:0] pc_inc_c;
  logic [W-1:0] instr_q, instr_d;
  logic [W-1:0] idpc_q, idpc_d;
  logic [W-1:0] idnext_q, idnext_d;
  logic         valid_q, valid_d;

  assign pc_inc_c = pc_q + STEP;

  // Select the single case that applies this cycle, highest priority first.
  always_comb begin
    case_c = C_FETCH;
    if (branch_taken)      case_c = C_REDIRECT;
    else if (flush)        case_c = C_FLUSH;
    else if (stall)        case_c = C_HOLD;
    else if (mem_conflict) case_c = C_CONFLICT;
  end

  // Next PC and IF/ID contents; a bubble keeps the old id_pc/id_pc_next.
  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    idpc_d   = idpc_q;
    idnext_d = idnext_q;
    valid_d  = valid_q;
    unique case (case_c)
      C_REDIRECT: begin
        pc_d    = branch_target;
        instr_d = NOP_WORD;
        valid_d = 1'b0;
      end
      C_FLUSH: begin
        pc_d    = stall ? pc_q : pc_inc_c;
        instr_d = NOP_WORD;
        valid_d = 1'b0;
      end
      C_HOLD: begin
      end
      C_CONFLICT: begin
        instr_d = NOP_WORD;
        valid_d = 1'b0;
      end
      default: begin
        pc_d     = pc_inc_c;
        instr_d  = imem_instr;
        idpc_d   = pc_q;
        idnext_d = pc_inc_c;
        valid_d  = 1'b1;
      end
    endcase
  end

  // PC and IF/ID state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      instr_q  <= NOP_WORD;
      idpc_q   <= '0;
      idnext_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      idpc_q   <= idpc_d;
      idnext_q <= idnext_d;
      valid_q  <= valid_d;
    end
  end

  assign imem_pc    = pc_q;
  assign id_instr   = instr_q;
  assign id_pc      = idpc_q;
  assign id_pc_next = idnext_q;
  assign id_valid   = valid_q;

`ifdef INSTRUCTION_FETCH_PERF_EN
  logic [W-1:0] fetched_q, fetched_d;
  logic [W-1:0] bubbles_q, bubbles_d;

  // Count real fetches and loaded bubbles; holds are not counted.
  always_comb begin
    fetched_d = fetched_q;
    bubbles_d = bubbles_q;
    if (case_c == C_FETCH)     fetched_d = fetched_q + W'(1);
    else if (case_c != C_HOLD) bubbles_d = bubbles_q + W'(1);
  end

  // Performance counter registers, wrapping at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetched_q <= '0;
      bubbles_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      bubbles_q <= bubbles_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_bubbles = bubbles_q;
`else
  assign perf_fetched = '0;
  assign perf_bubbles = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch. Memory model returns addr ^ 16'h5A00
// so instruction and address fields are distinguishable.
module tb_instruction_fetch;

`ifdef INSTRUCTION_FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam logic [15:0] NOP = 16'h0800;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] imem_pc;
  logic [15:0] imem_instr;
  logic        mem_conflict;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] id_instr;
  logic [15:0] id_pc;
  logic [15:0] id_pc_next;
  logic        id_valid;
  logic [15:0] perf_fetched;
  logic [15:0] perf_bubbles;

  int total = 0;
  int bad   = 0;

  instruction_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .imem_pc       (imem_pc),
    .imem_instr    (imem_instr),
    .mem_conflict  (mem_conflict),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .id_pc_next    (id_pc_next),
    .id_valid      (id_valid),
    .perf_fetched  (perf_fetched),
    .perf_bubbles  (perf_bubbles)
  );

  always #5 clk = ~clk;

  assign imem_instr = imem_pc ^ 16'h5A00;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] pc, input logic [15:0] ins,
                         input logic [15:0] ipc, input logic [15:0] inext, input logic v);
    chk({tag, ".imem_pc"}, imem_pc, pc);
    chk({tag, ".id_instr"}, id_instr, ins);
    chk({tag, ".id_pc"}, id_pc, ipc);
    chk({tag, ".id_pc_next"}, id_pc_next, inext);
    chk({tag, ".id_valid"}, 16'(id_valid), 16'(v));
  endtask

  task automatic chk_perf(input string tag, input logic [15:0] f, input logic [15:0] b);
    chk({tag, ".perf_fetched"}, perf_fetched, PERF ? f : 16'h0000);
    chk({tag, ".perf_bubbles"}, perf_bubbles, PERF ? b : 16'h0000);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; mem_conflict = 1'b0; stall = 1'b0; flush = 1'b0;
    branch_taken = 1'b0; branch_target = 16'h0000;
    step(); step();
    chk_all("reset", 16'h0000, NOP, 16'h0000, 16'h0000, 1'b0);
    chk_perf("reset", 16'd0, 16'd0);
    rst = 1'b0;

    // Free fetches
    step(); chk_all("fetch0", 16'h0004, 16'h5A00, 16'h0000, 16'h0004, 1'b1);
    step(); chk_all("fetch4", 16'h0008, 16'h5A04, 16'h0004, 16'h0008, 1'b1);

    // Stall 3 cycles: everything frozen
    stall = 1'b1;
    step(); chk_all("stall1", 16'h0008, 16'h5A04, 16'h0004, 16'h0008, 1'b1);
    step(); chk_all("stall2", 16'h0008, 16'h5A04, 16'h0004, 16'h0008, 1'b1);
    step(); chk_all("stall3", 16'h0008, 16'h5A04, 16'h0004, 16'h0008, 1'b1);
    stall = 1'b0;

    // Conflict 2 cycles at PC=8
    mem_conflict = 1'b1;
    step(); chk_all("conf1", 16'h0008, NOP, 16'h0004, 16'h0008, 1'b0);
    step(); chk_all("conf2", 16'h0008, NOP, 16'h0004, 16'h0008, 1'b0);
    mem_conflict = 1'b0;
    step(); chk_all("refetch8", 16'h000C, 16'h5A08, 16'h0008, 16'h000C, 1'b1);
    step(); chk_all("fetch12", 16'h0010, 16'h5A0C, 16'h000C, 16'h0010, 1'b1);
    step(); chk_all("fetch16", 16'h0014, 16'h5A10, 16'h0010, 16'h0014, 1'b1);

    // Redirect wins over stall and conflict
    branch_taken = 1'b1; branch_target = 16'h0040; stall = 1'b1; mem_conflict = 1'b1;
    step(); chk_all("redirect", 16'h0040, NOP, 16'h0010, 16'h0014, 1'b0);
    chk_perf("after_redirect", 16'd5, 16'd3);
    branch_taken = 1'b0; stall = 1'b0; mem_conflict = 1'b0;

    // Flush advances PC; flush with stall holds PC
    flush = 1'b1;
    step(); chk_all("flush", 16'h0044, NOP, 16'h0010, 16'h0014, 1'b0);
    stall = 1'b1;
    step(); chk_all("flush_stall", 16'h0044, NOP, 16'h0010, 16'h0014, 1'b0);
    flush = 1'b0; stall = 1'b0;
    step(); chk_all("fetch44", 16'h0048, 16'h5A44, 16'h0044, 16'h0048, 1'b1);

    // Wrap at 16'hFFFC
    branch_taken = 1'b1; branch_target = 16'hFFFC;
    step(); chk_all("redir_fffc", 16'hFFFC, NOP, 16'h0044, 16'h0048, 1'b0);
    branch_taken = 1'b0;
    step(); chk_all("wrap", 16'h0000, 16'hA5FC, 16'hFFFC, 16'h0000, 1'b1);
    chk_perf("before_rst", 16'd7, 16'd6);

    // Asynchronous reset pulse between edges
    step();
    rst = 1'b1;
    #1;
    chk_all("async_rst", 16'h0000, NOP, 16'h0000, 16'h0000, 1'b0);
    chk_perf("async_rst", 16'd0, 16'd0);
    step();
    rst = 1'b0;
    step(); chk_all("post_rst", 16'h0004, 16'h5A00, 16'h0000, 16'h0004, 1'b1);
    chk_perf("post_rst", 16'd1, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
